// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order writeback FIFO with scoreboard query for the register file
// Optional forwarding of the youngest pending value on QueryData: define REGFILE_WBQ_BYPASS_EN.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       AluValid,
    input  logic [ADDR_W-1:0]          AluReg,
    input  logic [DATA_W-1:0]          AluData,
    input  logic                       MemValid,
    input  logic [ADDR_W-1:0]          MemReg,
    input  logic [DATA_W-1:0]          MemData,
    output logic                       InReady,
    output logic [ADDR_W-1:0]          WriteRegister,
    output logic [DATA_W-1:0]          WriteData,
    output logic                       RegWrite,
    input  logic [ADDR_W-1:0]          QueryReg,
    output logic                       QueryPending,
    output logic [DATA_W-1:0]          QueryData,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_READY_MAX = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] ent_reg  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  alu_slot;
    logic [CNT_W-1:0]  num_push;
    logic [CNT_W-1:0]  count_next;
    logic              push_mem;
    logic              push_alu;
    logic              pop;
    logic              drop;
    logic              hit;

    // Admission looks only at Count so two pushes always fit, regardless of a same-edge pop.
    assign InReady  = (Count <= CNT_READY_MAX);
    assign push_mem = MemValid && InReady && (MemReg != '0);
    assign push_alu = AluValid && InReady && (AluReg != '0);
    assign drop     = (MemValid || AluValid) && !InReady;
    assign pop      = (Count != '0);

    assign num_push   = CNT_W'(push_mem) + CNT_W'(push_alu);
    assign count_next = Count + num_push - CNT_W'(pop);
    // Mem is the older instruction, so it takes the first free slot.
    assign alu_slot   = tail + PTR_W'(push_mem);

    always_ff @(posedge Clk) begin
        if (push_mem) begin
            ent_reg[tail]  <= MemReg;
            ent_data[tail] <= MemData;
        end
        if (push_alu) begin
            ent_reg[alu_slot]  <= AluReg;
            ent_data[alu_slot] <= AluData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Count         <= '0;
            head          <= '0;
            tail          <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            Overflow      <= 1'b0;
        end else begin
            Count <= count_next;
            tail  <= tail + num_push[PTR_W-1:0];
            if (pop) begin
                WriteRegister <= ent_reg[head];
                WriteData     <= ent_data[head];
                RegWrite      <= 1'b1;
                head          <= head + PTR_W'(1);
            end else begin
                RegWrite <= 1'b0;
            end
            if (drop) begin
                Overflow <= 1'b1;
            end
        end
    end

`ifdef REGFILE_WBQ_BYPASS_EN
    logic [DATA_W-1:0] bypass_data;
`endif

    // Walk head to tail so the last match seen is the youngest.
    always_comb begin
        hit = RegWrite && (WriteRegister == QueryReg);
`ifdef REGFILE_WBQ_BYPASS_EN
        bypass_data = hit ? WriteData : '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < Count) && (ent_reg[head + PTR_W'(k)] == QueryReg)) begin
                hit = 1'b1;
`ifdef REGFILE_WBQ_BYPASS_EN
                bypass_data = ent_data[head + PTR_W'(k)];
`endif
            end
        end
    end

    assign QueryPending = hit && (QueryReg != '0);

`ifdef REGFILE_WBQ_BYPASS_EN
    assign QueryData = (QueryReg != '0) ? bypass_data : '0;
`else
    assign QueryData = '0;
`endif

    assert property (@(posedge Clk) disable iff (!Reset_n) Count <= CNT_MAX);

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - vector table, corner sequences and random run against a queue model
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        AluValid, MemValid;
    logic [4:0]  AluReg, MemReg, QueryReg;
    logic [31:0] AluData, MemData;
    logic        InReady, RegWrite, QueryPending, Overflow;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData, QueryData;
    logic [2:0]  Count;

    regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
        .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData),
        .InReady(InReady), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .RegWrite(RegWrite), .QueryReg(QueryReg), .QueryPending(QueryPending),
        .QueryData(QueryData), .Count(Count), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic        m_ovf;

    typedef struct {
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic [4:0]  qr;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [2:0]  cnt;
        logic        pend;
        logic [31:0] qd;
    } vec_t;

    vec_t vecs[12];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_rw = 1'b0;
        m_wreg = '0;
        m_wdata = '0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_edge();
        bit   rdy;
        ent_t e;
        rdy = (mq.size() <= DEPTH - 2);
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_rw = 1'b1;
            m_wreg = e.r;
            m_wdata = e.d;
        end else begin
            m_rw = 1'b0;
        end
        if (MemValid) begin
            if (!rdy) m_ovf = 1'b1;
            else if (MemReg != 0) mq.push_back('{MemReg, MemData});
        end
        if (AluValid) begin
            if (!rdy) m_ovf = 1'b1;
            else if (AluReg != 0) mq.push_back('{AluReg, AluData});
        end
    endfunction

    function automatic void check_all();
        logic        pend;
        logic [31:0] qd;
        pend = 1'b0;
        qd = '0;
        if (m_rw && m_wreg == QueryReg) begin
            pend = 1'b1;
            qd = m_wdata;
        end
        foreach (mq[i]) begin
            if (mq[i].r == QueryReg) begin
                pend = 1'b1;
                qd = mq[i].d;
            end
        end
        if (QueryReg == 0) begin
            pend = 1'b0;
            qd = '0;
        end
`ifndef REGFILE_WBQ_BYPASS_EN
        qd = '0;
`endif
        chk("reg_write", 32'(RegWrite), 32'(m_rw));
        chk("write_register", 32'(WriteRegister), 32'(m_wreg));
        chk("write_data", WriteData, m_wdata);
        chk("count", 32'(Count), 32'(mq.size()));
        chk("in_ready", 32'(InReady), 32'(mq.size() <= DEPTH - 2));
        chk("overflow", 32'(Overflow), 32'(m_ovf));
        chk("query_pending", 32'(QueryPending), 32'(pend));
        chk("query_data", QueryData, qd);
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                          input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic [4:0] qr);
        MemValid = mv; MemReg = mr; MemData = md;
        AluValid = av; AluReg = ar; AluData = ad;
        QueryReg = qr;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all();
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8,  32'h1234,     5'd8,  1'b0, 5'd0,  32'h0,        3'd1, 1'b1, 32'h1234};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd8,  1'b1, 5'd8,  32'h1234,     3'd0, 1'b1, 32'h1234};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd8,  1'b0, 5'd8,  32'h1234,     3'd0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 5'd9, 32'hAAAAAAAA, 1'b1, 5'd10, 32'hBBBBBBBB, 5'd10, 1'b0, 5'd8,  32'h1234,     3'd2, 1'b1, 32'hBBBBBBBB};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  1'b1, 5'd9,  32'hAAAAAAAA, 3'd1, 1'b1, 32'hAAAAAAAA};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 1'b1, 5'd10, 32'hBBBBBBBB, 3'd0, 1'b1, 32'hBBBBBBBB};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  1'b0, 5'd10, 32'hBBBBBBBB, 3'd0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  1'b0, 5'd10, 32'hBBBBBBBB, 3'd0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8,  32'h1,        5'd8,  1'b0, 5'd10, 32'hBBBBBBBB, 3'd1, 1'b1, 32'h1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8,  32'h2,        5'd8,  1'b1, 5'd8,  32'h1,        3'd1, 1'b1, 32'h2};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd8,  1'b1, 5'd8,  32'h2,        3'd0, 1'b1, 32'h2};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        5'd8,  1'b0, 5'd8,  32'h2,        3'd0, 1'b0, 32'h0};

        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        do_reset();

        foreach (vecs[i]) begin
            set_in(vecs[i].mv, vecs[i].mr, vecs[i].md, vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].qr);
            tick();
            chk($sformatf("vec%0d_reg_write", i), 32'(RegWrite), 32'(vecs[i].rw));
            chk($sformatf("vec%0d_write_register", i), 32'(WriteRegister), 32'(vecs[i].wr));
            chk($sformatf("vec%0d_write_data", i), WriteData, vecs[i].wd);
            chk($sformatf("vec%0d_count", i), 32'(Count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_query_pending", i), 32'(QueryPending), 32'(vecs[i].pend));
`ifdef REGFILE_WBQ_BYPASS_EN
            chk($sformatf("vec%0d_query_data", i), QueryData, vecs[i].qd);
`else
            chk($sformatf("vec%0d_query_data", i), QueryData, 32'h0);
`endif
        end

        // Saturation: both producers every cycle until admission closes.
        for (int c = 0; c < 8; c++) begin
            set_in(1'b1, 5'(c * 2 + 1), 32'h100 + 32'(c), 1'b1, 5'(c * 2 + 2), 32'h200 + 32'(c), 5'd3);
            tick();
            if (c == 1) begin
                chk("sat_count_peak", 32'(Count), 32'd3);
                chk("sat_in_ready_low", 32'(InReady), 32'd0);
            end
            if (c == 2) chk("sat_overflow_set", 32'(Overflow), 32'd1);
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        repeat (5) tick();
        chk("sat_overflow_sticky", 32'(Overflow), 32'd1);
        chk("sat_drained", 32'(Count), 32'd0);

        // Async reset with three entries queued.
        set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55, 5'd6);
        tick();
        set_in(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 5'd6);
        tick();
        chk("rst_pre_count", 32'(Count), 32'd3);
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd6);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("rst_async_reg_write", 32'(RegWrite), 32'd0);
        chk("rst_async_count", 32'(Count), 32'd0);
        chk("rst_async_overflow", 32'(Overflow), 32'd0);
        chk("rst_async_write_register", 32'(WriteRegister), 32'd0);
        model_reset();
        #1;
        Reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_no_write", 32'(RegWrite), 32'd0);
        end

        // Random traffic with small register numbers so queries and reg-0 discards are frequent.
        for (int c = 0; c < 400; c++) begin
            set_in(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)));
            if (($urandom % 3) == 0) begin
                MemValid = 1'b0;
                AluValid = 1'b0;
            end
            tick();
            if (c == 200) begin
                set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
                do_reset();
                #1;
                check_all();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
